nibbler_control_fsm: RTL
========================

Name: nibbler_control_fsm

Overview:
Instruction sequencer for the 4-bit Nibbler datapath. It latches the opcode in a FETCH cycle and optionally waits on memory for memory-operand instructions. In EXEC it issues one-cycle enables to the PC, accumulator, Flags register, RAM and I/O ports. Jump conditions are resolved from the registered C/Zeta outputs of the Flags block, so conditional jumps always see the flags written by the previous instruction.

Parameters:
WAIT_CYCLES, 1, number of MEM_WAIT cycles inserted for memory-operand instructions; 0 skips MEM_WAIT entirely (legal range 0..15).
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
run  input  1  level; 1 = keep executing, 0 = park in IDLE after the current instruction.
instr  input  4  opcode from the program ROM, sampled in FETCH.
C_flag  input  1  registered carry flag (Flags.C_out).
Zeta_flag  input  1  registered zero flag (Flags.Zeta_out).
fetch_en  output  1  instruction-register load; high in FETCH.
pc_inc  output  1  PC increment; high in EXEC unless a jump is taken.
pc_load  output  1  PC load from the jump target; high in EXEC for a taken jump.
acc_en  output  1  accumulator load.
flags_en  output  1  drives Flags.enabled.
alu_op  output  2  00 pass-B, 01 add, 10 subtract (compare), 11 nand.
b_sel  output  1  ALU B source: 0 = immediate, 1 = RAM.
ram_cs  output  1  RAM chip select.
ram_we  output  1  RAM write strobe.
in_en  output  1  input-port read.
out_en  output  1  output-port write.
state  output  2  00 IDLE, 01 FETCH, 10 MEM_WAIT, 11 EXEC.
busy  output  1  state != IDLE.
retired  output  CNT_W  count of completed EXEC cycles; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, latched opcode=0, wait counter=0, retired=0. Every decoded output reads 0 immediately, without waiting for a clock edge. A reset asserted mid-instruction aborts it with no partial strobes.
- Outputs are combinational from state and the latched opcode; state, opcode, wait counter and retired are registered.
- Opcode map: 0 JC, 1 JNC, 2 CMPI, 3 CMPM, 4 LIT, 5 IN, 6 LD, 7 ST, 8 JZ, 9 JNZ, A ADDI, B ADDM, C JMP, D OUT, E NANDI, F NANDM.
- Memory-operand opcodes: CMPM, LD, ST, ADDM, NANDM.
- IDLE: all strobes 0. Go to FETCH on a clk edge with run=1.
- FETCH (1 cycle): fetch_en=1. Opcode latched from instr on the exiting edge.
  - Next state is MEM_WAIT if the opcode is a memory op and WAIT_CYCLES>0.
  - Otherwise next state is EXEC.
- MEM_WAIT: ram_cs=1, b_sel=1. The wait counter loads WAIT_CYCLES-1 on entry and decrements each cycle. Exit to EXEC on the edge where the counter is 0, giving exactly WAIT_CYCLES cycles. The run input is ignored here.
- EXEC (1 cycle) strobes:
  - acc_en: LIT, IN, LD, ADDI, ADDM, NANDI, NANDM.
  - flags_en: CMPI, CMPM, ADDI, ADDM, NANDI, NANDM.
  - alu_op: 10 for CMP*, 01 for ADD*, 11 for NAND*, 00 otherwise.
  - b_sel=1 and ram_cs=1 for memory ops.
  - ram_we=1 (with ram_cs=1) for ST only.
  - in_en=1 for IN; out_en=1 for OUT.
- Jump-taken conditions:
  - JC: C_flag=1. JNC: C_flag=0.
  - JZ: Zeta_flag=1. JNZ: Zeta_flag=0.
  - JMP: always taken.
- In EXEC: pc_load=taken, pc_inc=!taken. For non-jump opcodes pc_inc=1. Exactly one of pc_inc/pc_load is high in every EXEC cycle.
- EXEC exit edge: retired increments, wrapping from all-ones to 0. Next state is FETCH if run=1, else IDLE.
- Latency: 2 cycles per non-memory instruction; 2+WAIT_CYCLES cycles per memory instruction.
- Dropping run never truncates an instruction. If run returns to 1 while in IDLE, FETCH begins on the next edge.
- Strobes are never high in states other than those listed above.

Test Plan:
- Reset then run=1, instr=4 (LIT): FETCH at cycle 1, EXEC at cycle 2 with acc_en=1, pc_inc=1, flags_en=0; retired=1 after EXEC.
- WAIT_CYCLES=1, instr=B (ADDM): FETCH, 1 MEM_WAIT (ram_cs=1, b_sel=1), then EXEC with acc_en=1, flags_en=1, alu_op=01. Repeat with WAIT_CYCLES=3: exactly 3 MEM_WAIT cycles.
- instr=0 (JC) with C_flag=1 -> EXEC pc_load=1, pc_inc=0. With C_flag=0 -> pc_load=0, pc_inc=1. Same check for JZ/JNZ on Zeta_flag; JMP always gives pc_load=1.
- instr=7 (ST) -> ram_cs=1 and ram_we=1 for the single EXEC cycle only, acc_en=0, flags_en=0. instr=D (OUT) -> out_en=1 in EXEC.
- run dropped during MEM_WAIT of LD -> instruction completes (EXEC acc_en=1), then IDLE with busy=0. run=1 again -> FETCH on the next edge.
- rst asserted mid-EXEC between clock edges -> state=00 and every strobe 0 before the next edge, retired=0. CNT_W=4, 16 instructions -> retired wraps to 0.

Source files
------------

// File: rtl/nibbler_control_fsm.sv
// Nibbler instruction sequencer: IDLE -> FETCH -> [MEM_WAIT] -> EXEC.
// Ports: clk/rst, run, instr, C_flag/Zeta_flag in; datapath strobes,
//   state, busy and the retired-instruction count out.
module nibbler_control_fsm #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [3:0]       instr,
  input  logic             C_flag,
  input  logic             Zeta_flag,
  output logic             fetch_en,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             acc_en,
  output logic             flags_en,
  output logic [1:0]       alu_op,
  output logic             b_sel,
  output logic             ram_cs,
  output logic             ram_we,
  output logic             in_en,
  output logic             out_en,
  output logic [1:0]       state,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_WAIT  = 2'b10,
    S_EXEC  = 2'b11
  } state_t;

  typedef enum logic [3:0] {
    OP_JC    = 4'h0,
    OP_JNC   = 4'h1,
    OP_CMPI  = 4'h2,
    OP_CMPM  = 4'h3,
    OP_LIT   = 4'h4,
    OP_IN    = 4'h5,
    OP_LD    = 4'h6,
    OP_ST    = 4'h7,
    OP_JZ    = 4'h8,
    OP_JNZ   = 4'h9,
    OP_ADDI  = 4'hA,
    OP_ADDM  = 4'hB,
    OP_JMP   = 4'hC,
    OP_OUT   = 4'hD,
    OP_NANDI = 4'hE,
    OP_NANDM = 4'hF
  } op_t;

  localparam bit HAS_WAIT = (WAIT_CYCLES != 0);
  localparam logic [3:0] WAIT_LD =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t           cur;
  state_t           nxt;
  op_t              op_q;
  logic [3:0]       wcnt_q;
  logic [3:0]       wcnt_d;
  logic [CNT_W-1:0] ret_q;
  logic             taken;

  function automatic logic is_mem(input logic [3:0] o);
    logic m;
    m = 1'b0;
    unique case (o)
      OP_CMPM, OP_LD, OP_ST,
      OP_ADDM, OP_NANDM: m = 1'b1;
      default:           m = 1'b0;
    endcase
    return m;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur    <= S_IDLE;
      op_q   <= OP_JC;
      wcnt_q <= 4'd0;
      ret_q  <= '0;
    end else begin
      cur    <= nxt;
      wcnt_q <= wcnt_d;
      if (cur == S_FETCH)
        op_q <= op_t'(instr);
      if (cur == S_EXEC)
        ret_q <= ret_q + CNT_W'(1);
    end
  end

  // FETCH looks at the live opcode: it is latched on this same edge.
  always_comb begin
    nxt    = cur;
    wcnt_d = wcnt_q;
    unique case (cur)
      S_IDLE: begin
        if (run)
          nxt = S_FETCH;
      end
      S_FETCH: begin
        if (is_mem(instr) && HAS_WAIT) begin
          nxt    = S_WAIT;
          wcnt_d = WAIT_LD;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_WAIT: begin
        if (wcnt_q == 4'd0)
          nxt = S_EXEC;
        else
          wcnt_d = wcnt_q - 4'd1;
      end
      S_EXEC: begin
        nxt = run ? S_FETCH : S_IDLE;
      end
    endcase
  end

  // Flags are the registered outputs of the Flags block,
  // so they reflect the previous instruction.
  always_comb begin
    taken = 1'b0;
    unique case (op_q)
      OP_JC:   taken = C_flag;
      OP_JNC:  taken = ~C_flag;
      OP_JZ:   taken = Zeta_flag;
      OP_JNZ:  taken = ~Zeta_flag;
      OP_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    fetch_en = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    acc_en   = 1'b0;
    flags_en = 1'b0;
    alu_op   = 2'b00;
    b_sel    = 1'b0;
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    in_en    = 1'b0;
    out_en   = 1'b0;
    unique case (cur)
      S_IDLE: begin
      end
      S_FETCH: begin
        fetch_en = 1'b1;
      end
      S_WAIT: begin
        ram_cs = 1'b1;
        b_sel  = 1'b1;
      end
      S_EXEC: begin
        pc_load = taken;
        pc_inc  = ~taken;
        unique case (op_q)
          OP_CMPI: begin
            flags_en = 1'b1;
            alu_op   = 2'b10;
          end
          OP_CMPM: begin
            flags_en = 1'b1;
            alu_op   = 2'b10;
            b_sel    = 1'b1;
            ram_cs   = 1'b1;
          end
          OP_LIT: begin
            acc_en = 1'b1;
          end
          OP_IN: begin
            acc_en = 1'b1;
            in_en  = 1'b1;
          end
          OP_LD: begin
            acc_en = 1'b1;
            b_sel  = 1'b1;
            ram_cs = 1'b1;
          end
          OP_ST: begin
            b_sel  = 1'b1;
            ram_cs = 1'b1;
            ram_we = 1'b1;
          end
          OP_ADDI: begin
            acc_en   = 1'b1;
            flags_en = 1'b1;
            alu_op   = 2'b01;
          end
          OP_ADDM: begin
            acc_en   = 1'b1;
            flags_en = 1'b1;
            alu_op   = 2'b01;
            b_sel    = 1'b1;
            ram_cs   = 1'b1;
          end
          OP_OUT: begin
            out_en = 1'b1;
          end
          OP_NANDI: begin
            acc_en   = 1'b1;
            flags_en = 1'b1;
            alu_op   = 2'b11;
          end
          OP_NANDM: begin
            acc_en   = 1'b1;
            flags_en = 1'b1;
            alu_op   = 2'b11;
            b_sel    = 1'b1;
            ram_cs   = 1'b1;
          end
          default: begin
          end
        endcase
      end
    endcase
  end

  assign state   = cur;
  assign busy    = (cur != S_IDLE);
  assign retired = ret_q;

endmodule
